// File: rtl/vga_scanout_pkg.sv
// Shared constants for the 640x480@60 RGB444 scan-out: timing, colour
// fields, colour-bar table and the bar-index helper.
package vga_scanout_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_AW       = 19;
    localparam logic VGA_HS_POL = 1'b0;
    localparam logic VGA_VS_POL = 1'b0;

    // RGB444 word as stored in VRAM: {R[11:8], G[7:4], B[3:0]}
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Colour bars, index 0 is the leftmost bar
    localparam logic [7:0][11:0] BAR = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};

    // Which of the 8 equal-width bars column x falls in (constant compares, no divider)
    function automatic logic [2:0] bar_index(input int x, input int h_active);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= (i * h_active) / 8) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Read-only VRAM port B: scan-out drives the address, VRAM returns data 1 clk later.
interface vga_scanout_if #(parameter int AW = 19);
    logic [AW-1:0] vram_addr;
    logic [11:0]   vram_dout;

    modport master (output vram_addr, input vram_dout);
    modport slave  (input vram_addr, output vram_dout);
endinterface

// File: rtl/vga_scanout_timing.sv
// Raster counters plus undelayed sync/active/vblank flags and frame markers.
module vga_scanout_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    parameter int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    parameter int HW       = $clog2(H_TOTAL),
    parameter int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_o,
    output logic          active_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          vblank_o,
    output logic          frame_start_o,
    output logic          sof_o,
    output logic          eof_o
);
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          fs_q;

    // Next raster position; v advances on h wrap, both wrap together at frame end
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    // Counter state and the frame-start pulse (fires the cycle after (0,0) is held)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q  <= '0;
            v_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            fs_q <= sof_o;
        end
    end

    assign h_o           = h_q;
    assign sof_o         = (h_q == '0) && (v_q == '0);
    assign eof_o         = (h_q == HW'(H_TOTAL - 1)) && (v_q == VW'(V_TOTAL - 1));
    assign active_o      = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hs_o          = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_o          = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign vblank_o      = (v_q >= VW'(V_ACTIVE));
    assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, incremental VRAM address, per-frame mode latch
// and a fixed 2-clk pipeline from counters to the connector pins.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = VGA_HS_POL,
    parameter logic VS_POL   = VGA_VS_POL,
    parameter int   AW       = VGA_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 test_mode_i,
    vga_scanout_if.master        vram,
    output logic [3:0]           vga_r_o,
    output logic [3:0]           vga_g_o,
    output logic [3:0]           vga_b_o,
    output logic                 vga_hs_o,
    output logic                 vga_vs_o,
    output logic                 vblank_o,
    output logic                 frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE * V_ACTIVE - 1);

    logic [HW-1:0] h0;
    logic          active0, hs0, vs0, sof, eof;
    logic [2:0]    bar0;

    vga_scanout_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .h_o           (h0),
        .active_o      (active0),
        .hs_o          (hs0),
        .vs_o          (vs0),
        .vblank_o      (vblank_o),
        .frame_start_o (frame_start_o),
        .sof_o         (sof),
        .eof_o         (eof)
    );

    assign bar0 = bar_index(int'(h0), H_ACTIVE);

    logic [AW-1:0] addr_q, addr_d;
    logic          en_q, tm_q;
    logic          act1_q, hs1_q, vs1_q;
    logic [2:0]    bar1_q;
    rgb444_t       rgb_q, rgb_d;
    logic          hs_q, vs_q;

    // Address steps on visible pixels only, parks on the last pixel through
    // vblank and restarts at 0 as the raster re-enters (0,0)
    always_comb begin
        addr_d = addr_q;
        if (eof)                                 addr_d = '0;
        else if (active0 && addr_q != LAST_ADDR) addr_d = addr_q + AW'(1);
    end

    // Address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

    assign vram.vram_addr = addr_q;

    // Mode is captured once per frame so a frame is never torn
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
            tm_q <= 1'b0;
        end else if (sof) begin
            en_q <= enable_i;
            tm_q <= test_mode_i;
        end
    end

    // Stage 1: delay the raster flags while VRAM returns data for this address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            bar1_q <= '0;
        end else begin
            act1_q <= active0;
            hs1_q  <= hs0;
            vs1_q  <= vs0;
            bar1_q <= bar0;
        end
    end

    // Pixel source select: black in blanking or when disabled, bars, or VRAM
    always_comb begin
        rgb_d = '0;
        if (act1_q && en_q) begin
            if (tm_q) rgb_d = rgb444_t'(BAR[bar1_q]);
            else      rgb_d = rgb444_t'(vram.vram_dout);
        end
    end

    // Stage 2: registered pins, sync translated to the configured polarity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs1_q ? HS_POL : ~HS_POL;
            vs_q  <= vs1_q ? VS_POL : ~VS_POL;
        end
    end

    assign vga_r_o  = rgb_q.r;
    assign vga_g_o  = rgb_q.g;
    assign vga_b_o  = rgb_q.b;
    assign vga_hs_o = hs_q;
    assign vga_vs_o = vs_q;
endmodule
